lsu_mem_initiator: RTL and testbench

Load/store initiator for the M0 data memory: accepts byte/halfword load and store requests from the CPU memory stage over a valid/ready handshake and drives the word-organised memory's address, write-data and write-enable pins. Byte stores are performed as read-modify-write, and loads return sign- or zero-extended data. Sits between the pipeline's MEM stage and the 16-bit, combinational-read, posedge-write data memory.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_byte_lane.sv | 41 ++++
 rtl/lsu_mem_initiator.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared state encoding, access-size constants and address helper for the
// M0 data-memory load/store initiator.
package lsu_pkg;

    localparam int LSU_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_t;

    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_HALF = 1'b1;

    // The memory is word-organised; the lane bit is dropped and the top bit cleared.
    function automatic logic [LSU_ADDR_W-1:0] word_addr(input logic [LSU_ADDR_W-1:0] byte_addr);
        return {1'b0, byte_addr[LSU_ADDR_W-1:1]};
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian byte-lane handling: load extraction with sign/zero extension
// and the byte merge used by read-modify-write stores.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] word,
    input  logic                 lane,
    input  logic                 size,
    input  logic                 is_signed,
    input  logic [7:0]           store_byte,
    output logic [WORD_SIZE-1:0] load_data,
    output logic [WORD_SIZE-1:0] merged
);

    logic [7:0] lane_byte_s;

    // Load result: whole word for halfwords, extended lane byte otherwise.
    always_comb begin
        lane_byte_s = (lane == 1'b1) ? word[15:8] : word[7:0];
        if (size == SZ_HALF) begin
            load_data = word;
        end else if (is_signed == 1'b1) begin
            load_data = {{(WORD_SIZE-8){lane_byte_s[7]}}, lane_byte_s};
        end else begin
            load_data = {{(WORD_SIZE-8){1'b0}}, lane_byte_s};
        end
    end

    // Store merge: replace only the addressed lane of the word just read.
    always_comb begin
        merged = word;
        if (lane == 1'b1) begin
            merged[15:8] = store_byte;
        end else begin
            merged[7:0] = store_byte;
        end
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the M0 16-bit data memory. Optional misaligned
// halfword rejection is built in when LSU_ALIGN_CHECK_EN is defined.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_size,
    input  logic                 req_signed,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 mem_write
);

    lsu_state_t           state_r;
    logic                 write_r;
    logic                 size_r;
    logic                 signed_r;
    logic                 lane_r;
    logic [7:0]           byte_r;
    logic                 req_ready_r;
    logic                 resp_valid_r;
    logic [WORD_SIZE-1:0] resp_rdata_r;
    logic                 resp_err_r;
    logic [ADDR_SIZE-1:0] mem_address_r;
    logic [WORD_SIZE-1:0] mem_wdata_r;
    logic                 mem_write_r;
    logic [WORD_SIZE-1:0] load_data_s;
    logic [WORD_SIZE-1:0] merged_s;
    logic                 misaligned_s;

    lsu_byte_lane #(.WORD_SIZE(WORD_SIZE)) u_byte_lane (
        .word       (mem_rdata),
        .lane       (lane_r),
        .size       (size_r),
        .is_signed  (signed_r),
        .store_byte (byte_r),
        .load_data  (load_data_s),
        .merged     (merged_s)
    );

    // Misaligned halfwords are rejected only when the alignment check is built in.
    always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
        misaligned_s = (req_size == SZ_HALF) && (req_addr[0] == 1'b1);
`else
        misaligned_s = 1'b0;
`endif
    end

    // Request FSM; mem_write is set on the edge entering ACCESS/WRITE and cleared on leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            write_r       <= 1'b0;
            size_r        <= SZ_BYTE;
            signed_r      <= 1'b0;
            lane_r        <= 1'b0;
            byte_r        <= 8'h00;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= {WORD_SIZE{1'b0}};
            resp_err_r    <= 1'b0;
            mem_address_r <= {ADDR_SIZE{1'b0}};
            mem_wdata_r   <= {WORD_SIZE{1'b0}};
            mem_write_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_r     <= req_write;
                        size_r      <= req_size;
                        signed_r    <= req_signed;
                        lane_r      <= req_addr[0];
                        byte_r      <= req_wdata[7:0];
                        req_ready_r <= 1'b0;
                        if (misaligned_s) begin
                            state_r      <= ST_DONE;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= {WORD_SIZE{1'b0}};
                            resp_err_r   <= 1'b1;
                        end else begin
                            state_r       <= ST_ACCESS;
                            mem_address_r <= word_addr(req_addr);
                            if (req_write && (req_size == SZ_HALF)) begin
                                mem_wdata_r <= req_wdata;
                                mem_write_r <= 1'b1;
                            end else begin
                                mem_write_r <= 1'b0;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (write_r && (size_r == SZ_BYTE)) begin
                        mem_wdata_r <= merged_s;
                        mem_write_r <= 1'b1;
                        state_r     <= ST_WRITE;
                    end else begin
                        mem_write_r  <= 1'b0;
                        state_r      <= ST_DONE;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= write_r ? {WORD_SIZE{1'b0}} : load_data_s;
                    end
                end
                ST_WRITE: begin
                    mem_write_r  <= 1'b0;
                    state_r      <= ST_DONE;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= {WORD_SIZE{1'b0}};
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    mem_write_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign resp_valid  = resp_valid_r;
    assign resp_rdata  = resp_rdata_r;
    assign resp_err    = resp_err_r;
    assign mem_address = mem_address_r;
    assign mem_wdata   = mem_wdata_r;
    assign mem_write   = mem_write_r;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: a driver issues directed and random
// requests and predicts results from a word-array model; a monitor checks responses.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_size = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_write;

    lsu_mem_initiator dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        int          nwr;
        logic [15:0] waddr;
        logic [15:0] word;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mem [0:65535];
    logic [15:0] ref_mem [0:65535];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          hold_next = 0;

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // Memory: combinational read, posedge write
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_address] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_address];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Predict the response and memory effect, then drive the request for one accept edge
    task automatic issue(input logic wr, input logic sz, input logic sg,
                         input logic [15:0] a, input logic [15:0] d, input int hold);
        exp_t e;
        int   k;
        int   b;
        int   w;
        logic bad;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        w = int'(a) / 2;
`ifdef LSU_ALIGN_CHECK_EN
        bad = sz && (a % 2 == 1);
`else
        bad = 1'b0;
`endif
        e.acc = cyc + 1;
        e.waddr = 16'(w);
        e.rdata = 16'h0000;
        e.err = 1'b0;
        e.nwr = 0;
        if (bad) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!wr) begin
            e.lat = 2;
            if (sz) begin
                e.rdata = ref_mem[w];
            end else begin
                b = (int'(ref_mem[w]) >> (8 * (int'(a) % 2))) % 256;
                e.rdata = (sg && b >= 128) ? 16'(b + 65280) : 16'(b);
            end
        end else if (sz) begin
            e.lat = 2;
            e.nwr = 1;
            ref_mem[w] = d;
        end else begin
            e.lat = 3;
            e.nwr = 1;
            if (a % 2 == 1) ref_mem[w] = 16'((int'(ref_mem[w]) % 256) + (int'(d) % 256) * 256);
            else            ref_mem[w] = 16'((int'(ref_mem[w]) / 256) * 256 + (int'(d) % 256));
        end
        e.word = ref_mem[w];
        hold_next = hold;
        q.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each new response, checks hold-stability and the return to idle
    initial begin : monitor
        exp_t        e;
        logic        in_resp;
        logic        after_hs;
        int          wcount;
        int          held;
        int          hold_tgt;
        logic [15:0] waddr;
        logic [15:0] cap_rdata;
        logic        cap_err;
        in_resp = 1'b0; after_hs = 1'b0; wcount = 0; held = 0; hold_tgt = 0;
        waddr = 16'h0000; cap_rdata = 16'h0000; cap_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_resp = 1'b0; after_hs = 1'b0; wcount = 0; resp_ready = 1'b0;
            end else begin
                if (mem_write) begin
                    wcount++;
                    waddr = mem_address;
                end
                if (after_hs) begin
                    chk("idle_after_handshake", {req_ready, resp_valid}, {1'b1, 1'b0});
                    after_hs = 1'b0;
                end
                if (resp_valid) begin
                    if (!in_resp) begin
                        if (q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_response: got rdata %0h expected none", resp_rdata);
                        end else begin
                            e = q.pop_front();
                            chk("resp_rdata", resp_rdata, e.rdata);
                            chk("resp_err", resp_err, e.err);
                            chk("latency", cyc - e.acc + 1, e.lat);
                            chk("mem_write_cycles", wcount, e.nwr);
                            if (e.nwr != 0) chk("write_address", waddr, e.waddr);
                            chk("memory_word", mem[e.waddr], e.word);
                        end
                        in_resp = 1'b1;
                        held = 0;
                        hold_tgt = hold_next;
                        cap_rdata = resp_rdata;
                        cap_err = resp_err;
                        wcount = 0;
                    end else begin
                        chk("hold_rdata", resp_rdata, cap_rdata);
                        chk("hold_err", resp_err, cap_err);
                        chk("hold_quiet", {req_ready, mem_write}, {1'b0, 1'b0});
                    end
                    if (held < hold_tgt) begin
                        resp_ready = 1'b0;
                        held++;
                    end else begin
                        resp_ready = 1'b1;
                        after_hs = 1'b1;
                        in_resp = 1'b0;
                    end
                end else begin
                    resp_ready = 1'b0;
                end
            end
        end
    end

    // Driver: reset checks, directed test-plan sequence, reset during WRITE, random traffic
    initial begin : driver
        int k;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_resp", {resp_valid, resp_err, resp_rdata}, 18'h0);
        chk("reset_mem", {mem_write, mem_address, mem_wdata}, 33'h0);
        #1 rst = 1'b0;

        issue(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 0);
        issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0);
        issue(1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234, 1);
        issue(1'b1, 1'b0, 1'b0, 16'h0021, 16'h77AB, 0);
        issue(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 0);
        issue(1'b1, 1'b1, 1'b0, 16'h0030, 16'h80FF, 0);
        issue(1'b0, 1'b0, 1'b1, 16'h0031, 16'h0000, 0);
        issue(1'b0, 1'b0, 1'b0, 16'h0031, 16'h0000, 2);
        issue(1'b0, 1'b0, 1'b1, 16'h0030, 16'h0000, 0);
        issue(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 5);
        issue(1'b1, 1'b1, 1'b0, 16'h0041, 16'h5A5A, 0);
        issue(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 0);

        // Byte store interrupted by reset in WRITE must not commit
        k = 0;
        @(negedge clk);
        while ((!req_ready || q.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b1; req_write = 1'b1; req_size = 1'b0; req_signed = 1'b0;
        req_addr = 16'h0051; req_wdata = 16'h00C3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_write_req_ready", req_ready, 1);
        chk("rst_write_resp", {resp_valid, resp_err, resp_rdata}, 18'h0);
        chk("rst_write_mem", {mem_write, mem_address, mem_wdata}, 33'h0);
        repeat (2) @(negedge clk);
        chk("rst_write_no_commit", mem[16'h0028], ref_mem[16'h0028]);
        #1 rst = 1'b0;

        for (int n = 0; n < 150; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  a, 16'($urandom), $urandom_range(0, 2));
        end

        k = 0;
        while ((q.size() != 0 || resp_valid) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_scoreboard", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
